sha_padder: RTL and testbench

Upstream stage of `sha_engine`: it accepts a byte-granular message as a stream of 64-bit big-endian beats and produces padded FIPS 180-4 message blocks. Blocks are 512-bit for SHA-1/224/256 and 1024-bit for SHA-384/512/512_224/512_256. Each block is presented on a valid/ready port that connects directly to the engine's `valid`/`ready`/`mode`/`msg`. A `last` flag marks the final block of each message.

---
 rtl/sha_pkg.sv | 37 +++
 rtl/sha_padder_buf.sv | 57 +++++
 rtl/sha_padder.sv | 168 ++++++++++++++++
 tb/tb_sha_padder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared SHA types: mode selector, message block view and block-geometry helpers.
// 32-bit modes use the low 512 bits of msg_t (w32[15:0]); 64-bit modes use all of w64.
package sha;

  typedef enum logic [2:0] {
    sha1       = 3'd0,
    sha224     = 3'd1,
    sha256     = 3'd2,
    sha384     = 3'd3,
    sha512     = 3'd4,
    sha512_224 = 3'd5,
    sha512_256 = 3'd6
  } mode_t;

  typedef union packed {
    logic [15:0][63:0] w64;
    logic [31:0][31:0] w32;
  } msg_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic logic is_64(mode_t m);
    case (m)
      sha384, sha512, sha512_224, sha512_256: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] blk_bytes(mode_t m);
    return is_64(m) ? 8'd128 : 8'd64;
  endfunction

  function automatic logic [7:0] len_bytes(mode_t m);
    return is_64(m) ? 8'd16 : 8'd8;
  endfunction

endpackage

// File: rtl/sha_padder_buf.sv
// 128-byte block register, byte i = message byte i of the block.
// Per-cycle updates layer as: clear, pad/zero fill, lane insert, length insert (later wins).
module sha_padder_buf
  import sha::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [7:0]        wr_off,
  input  logic [63:0]       wr_data,
  input  logic [3:0]        wr_n,
  input  logic              pad_en,
  input  logic [7:0]        pad_idx,
  input  logic [7:0]        blk_end,
  input  logic              len_en,
  input  logic [63:0]       len_val,
  output logic [127:0][7:0] bytes_o
);

  logic [127:0][7:0] byte_q, byte_d;

  always_comb begin
    logic [7:0] ib;
    logic [7:0] wr_hi;
    logic [7:0] len_lo;
    logic [2:0] k;
    byte_d = byte_q;
    wr_hi  = 8'(wr_off + {4'b0, wr_n});
    len_lo = 8'(blk_end - 8'd8);
    ib     = '0;
    k      = '0;
    for (int i = 0; i < 128; i++) begin
      ib = 8'(i);
      if (clr) byte_d[i] = 8'h00;
      if (pad_en && ib > pad_idx && ib < blk_end) byte_d[i] = 8'h00;
      if (pad_en && ib == pad_idx) byte_d[i] = PAD_BYTE;
      if (wr_en && ib >= wr_off && ib < wr_hi) begin
        k = 3'(ib - wr_off);
        byte_d[i] = wr_data[{~k, 3'b000} +: 8];
      end
      // Length is big-endian in the final 8 bytes; the upper 8 (64-bit modes) stay zero.
      if (len_en && ib >= len_lo && ib < blk_end) begin
        k = 3'(ib - len_lo);
        byte_d[i] = len_val[{~k, 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) byte_q <= '0;
    else       byte_q <= byte_d;
  end

  assign bytes_o = byte_q;

endmodule

// File: rtl/sha_padder.sv
// Packs 64-bit big-endian beats into FIPS 180-4 padded blocks for sha_engine.
// Fill and emit never overlap: in_ready drops while a block is offered, block held until out_ready.
module sha_padder
  import sha::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_nbytes,
  input  mode_t       in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output mode_t       out_mode,
  output msg_t        out_msg,
  output logic        out_last
);

  typedef enum logic [1:0] {ST_FILL, ST_EMIT, ST_EXTRA} st_t;

  st_t         state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [63:0] cnt_q, cnt_d;
  mode_t       mode_q, mode_d;
  logic        last_q, last_d;
  logic        final_q, final_d;
  logic        extra_q, extra_d;
  logic        mark_q, mark_d;

  logic        clr, wr_en, pad_en, len_en;
  logic [7:0]  pad_idx, blk_end;
  logic [3:0]  n;
  logic [63:0] len_val;
  logic [127:0][7:0] blk;

  always_comb begin
    mode_t      m;
    logic [7:0] p;
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    last_d  = last_q;
    final_d = final_q;
    extra_d = extra_q;
    mark_d  = mark_q;
    clr     = 1'b0;
    wr_en   = 1'b0;
    pad_en  = 1'b0;
    len_en  = 1'b0;
    pad_idx = '0;
    len_val = '0;
    in_ready  = (state_q == ST_FILL);
    out_valid = (state_q == ST_EMIT);
    n = !in_last ? 4'd8 : (in_nbytes > 4'd8 ? 4'd8 : in_nbytes);
    // A beat at ptr 0 with nothing counted yet opens a new message and fixes its mode.
    m = (state_q == ST_FILL && ptr_q == 8'd0 && cnt_q == 64'd0) ? in_mode : mode_q;
    blk_end = blk_bytes(m);
    p = 8'(ptr_q + {4'b0, n});
    unique case (state_q)
      ST_FILL: if (in_valid) begin
        mode_d = m;
        wr_en  = 1'b1;
        cnt_d  = cnt_q + {60'b0, n};
        ptr_d  = p;
        if (!in_last) begin
          if (p == blk_end) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
            final_d = 1'b0;
            extra_d = 1'b0;
          end
        end else begin
          state_d = ST_EMIT;
          pad_en  = (p < blk_end);
          pad_idx = p;
          if (8'(p + 8'd1 + len_bytes(m)) <= blk_end) begin
            len_en  = 1'b1;
            len_val = {cnt_d[60:0], 3'b000};
            last_d  = 1'b1;
            final_d = 1'b1;
            extra_d = 1'b0;
          end else begin
            last_d  = 1'b0;
            final_d = 1'b0;
            extra_d = 1'b1;
            mark_d  = (p == blk_end);
          end
        end
      end
      ST_EMIT: if (out_ready) begin
        ptr_d = '0;
        if (extra_q) begin
          state_d = ST_EXTRA;
          extra_d = 1'b0;
        end else begin
          state_d = ST_FILL;
          if (final_q) cnt_d = '0;
        end
      end
      ST_EXTRA: begin
        clr     = 1'b1;
        pad_en  = mark_q;
        pad_idx = '0;
        len_en  = 1'b1;
        len_val = {cnt_q[60:0], 3'b000};
        last_d  = 1'b1;
        final_d = 1'b1;
        state_d = ST_EMIT;
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FILL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= sha1;
      last_q  <= 1'b0;
      final_q <= 1'b0;
      extra_q <= 1'b0;
      mark_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      final_q <= final_d;
      extra_q <= extra_d;
      mark_q  <= mark_d;
    end
  end

  sha_padder_buf u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_off  (ptr_q),
    .wr_data (in_data),
    .wr_n    (n),
    .pad_en  (pad_en),
    .pad_idx (pad_idx),
    .blk_end (blk_end),
    .len_en  (len_en),
    .len_val (len_val),
    .bytes_o (blk)
  );

  always_comb begin
    logic [1023:0] flat;
    flat = '0;
    for (int i = 0; i < 128; i++) begin
      if (is_64(mode_q))  flat[1023 - 8*i -: 8] = blk[i];
      else if (i < 64)    flat[511 - 8*i -: 8]  = blk[i];
    end
    out_msg = flat;
  end

  assign out_mode = mode_q;
  assign out_last = last_q;

endmodule

// File: tb/tb_sha_padder.sv
// Directed bench for sha_padder: known digests' padded blocks, boundary lengths,
// backpressure hold and mid-message reset.
module tb_sha_padder;
  import sha::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_nbytes;
  mode_t       in_mode;
  logic        out_valid;
  logic        out_ready;
  mode_t       out_mode;
  msg_t        out_msg;
  logic        out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sha_padder dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_nbytes (in_nbytes),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_msg   (out_msg),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input msg_t obs, input msg_t exp);
    int w;
    checks++;
    assert (obs === exp) else begin
      errors++;
      w = 15;
      while (w > 0 && obs.w64[w] === exp.w64[w]) w--;
      $error("FAIL %s w64[%0d] observed=%h expected=%h", tag, w, obs.w64[w], exp.w64[w]);
    end
  endtask

  function automatic logic [63:0] beat(int k);
    logic [63:0] d;
    d = '0;
    for (int m = 0; m < 8; m++) d[63 - 8*m -: 8] = 8'(8*k + m);
    return d;
  endfunction

  // 32-bit-mode block whose first nb bytes hold byte value j at index j.
  function automatic msg_t data_blk(int nb);
    logic [1023:0] e;
    e = '0;
    for (int j = 0; j < nb; j++) e[511 - 8*j -: 8] = 8'(j);
    return e;
  endfunction

  task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb, input mode_t md);
    int guard;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb; in_mode = md;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int guard;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  msg_t exp, held;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_nbytes = '0; in_mode = sha1; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk_msg("rst_out_msg", out_msg, '0);
    chk("rst_out_mode", 64'(out_mode), 64'(sha1));
    rstn = 1'b1;
    @(negedge clk);

    // SHA-256 "abc"
    send(64'h6162630000000000, 1'b1, 4'd3, sha256);
    wait_valid("abc_valid");
    exp = '0; exp.w32[15] = 32'h61626380; exp.w32[0] = 32'h00000018;
    chk_msg("abc_msg", out_msg, exp);
    chk("abc_last", 64'(out_last), 64'd1);
    chk("abc_mode", 64'(out_mode), 64'(sha256));
    chk("abc_in_ready_emit", 64'(in_ready), 64'd0);
    handshake();
    chk("abc_in_ready_after", 64'(in_ready), 64'd1);
    chk("abc_valid_after", 64'(out_valid), 64'd0);

    // SHA-512 empty message
    send(64'h0, 1'b1, 4'd0, sha512);
    wait_valid("e512_valid");
    exp = '0; exp.w64[15] = 64'h8000000000000000;
    chk_msg("e512_msg", out_msg, exp);
    chk("e512_last", 64'(out_last), 64'd1);
    chk("e512_mode", 64'(out_mode), 64'(sha512));
    handshake();

    // SHA-256, 56 bytes: pad byte fits, length spills into an extra block
    for (int k = 0; k < 7; k++) send(beat(k), k == 6, 4'd8, sha256);
    wait_valid("b56_valid1");
    exp = data_blk(56); exp.w32[1] = 32'h80000000;
    chk_msg("b56_msg1", out_msg, exp);
    chk("b56_last1", 64'(out_last), 64'd0);
    handshake();
    chk("b56_gap_valid", 64'(out_valid), 64'd0);
    chk("b56_gap_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("b56_extra_valid", 64'(out_valid), 64'd1);
    exp = '0; exp.w32[0] = 32'h000001C0;
    chk_msg("b56_msg2", out_msg, exp);
    chk("b56_last2", 64'(out_last), 64'd1);
    handshake();

    // SHA-256, 64 bytes: pad byte and length both go to the extra block
    for (int k = 0; k < 8; k++) send(beat(k), k == 7, 4'd8, sha256);
    wait_valid("b64_valid1");
    chk_msg("b64_msg1", out_msg, data_blk(64));
    chk("b64_last1", 64'(out_last), 64'd0);
    handshake();
    wait_valid("b64_valid2");
    exp = '0; exp.w32[15] = 32'h80000000; exp.w32[0] = 32'h00000200;
    chk_msg("b64_msg2", out_msg, exp);
    chk("b64_last2", 64'(out_last), 64'd1);
    handshake();

    // Backpressure: hold out_ready low for 10 cycles
    send(64'h6162630000000000, 1'b1, 4'd3, sha256);
    wait_valid("bp_valid");
    held = out_msg;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk_msg("bp_hold_msg", out_msg, held);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    handshake();
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a SHA-512 fill
    for (int k = 0; k < 3; k++) send(beat(k), 1'b0, 4'd8, sha512);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk_msg("mid_rst_out_msg", out_msg, '0);
    chk("mid_rst_out_mode", 64'(out_mode), 64'(sha1));
    @(negedge clk);
    rstn = 1'b1;
    send(64'h6162630000000000, 1'b1, 4'd3, sha256);
    wait_valid("post_rst_valid");
    exp = '0; exp.w32[15] = 32'h61626380; exp.w32[0] = 32'h00000018;
    chk_msg("post_rst_msg", out_msg, exp);
    chk("post_rst_last", 64'(out_last), 64'd1);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
